// File: rtl/sum_pkg.sv
// Shared definitions for the prefix-sum decoder: FSM state encoding and
// default frame/data geometry.
package sum_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 8;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/sum_decode_if.sv
// Valid/ready stream bundle carrying one data word plus an end-of-frame flag.
interface sum_decode_if
  import sum_pkg::*;
#(
  parameter int W = W_DEF
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         last;

  modport master (output data, output valid, output last, input  ready);
  modport slave  (input  data, input  valid, input  last, output ready);

endinterface

// File: rtl/sum_out_reg.sv
// Single output register stage: loads on input transfer, drops valid once the
// sink has taken the word and nothing new arrived.
module sum_out_reg
  import sum_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic          clk_25mhz,
  input  logic          reset,
  input  logic          i_load,
  input  logic [W-1:0]  i_data,
  input  logic          i_last,
  sum_decode_if.master  o_bus
);

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_last;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (o_bus.ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_bus.data  = r_data;
  assign o_bus.valid = r_valid;
  assign o_bus.last  = r_last;

endmodule

// File: rtl/sum_decode.sv
// Recovers frame elements from a stream of running (prefix) sums by
// differencing consecutive samples within each N-sample frame.
module sum_decode
  import sum_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk_25mhz,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [7:0]   led
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [W-1:0]     r_prev;
  logic [W-1:0]     w_elem;
  logic [7:0]       r_led;
  logic [7:0]       w_led_next;
  logic             w_in_ready;
  logic             w_in_xfer;
  logic             w_at_last;

  sum_decode_if #(.W(W)) u_out_if ();

  // Reset and clr both stall the input for their cycle.
  assign w_in_ready = !reset && !clr && (!u_out_if.valid || out_ready);
  assign w_in_xfer  = in_valid && w_in_ready;
  assign w_at_last  = (r_idx == LAST_IDX);
  assign w_elem     = (r_state == ST_FIRST) ? in_data : in_data - r_prev;

  if (W >= 8) begin : g_led_trunc
    assign w_led_next = in_data[7:0];
  end else begin : g_led_ext
    assign w_led_next = {{(8 - W){1'b0}}, in_data};
  end

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    if (clr) begin
      w_state_next = ST_FIRST;
      w_idx_next   = '0;
    end else if (w_in_xfer) begin
      w_idx_next = w_at_last ? '0 : r_idx + IDX_W'(1);
      case (r_state)
        ST_FIRST: w_state_next = ST_RUN;
        ST_RUN:   w_state_next = w_at_last ? ST_FIRST : ST_RUN;
        default:  w_state_next = ST_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_state <= ST_FIRST;
      r_idx   <= '0;
      r_prev  <= '0;
      r_led   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (clr) begin
        r_prev <= '0;
      end else if (w_in_xfer) begin
        r_prev <= in_data;
      end
      if (w_in_xfer && w_at_last) begin
        r_led <= w_led_next;
      end
    end
  end

  sum_out_reg #(.W(W)) u_out_reg (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .i_load    (w_in_xfer),
    .i_data    (w_elem),
    .i_last    (w_at_last),
    .o_bus     (u_out_if)
  );

  assign u_out_if.ready = out_ready;
  assign in_ready       = w_in_ready;
  assign out_data       = u_out_if.data;
  assign out_valid      = u_out_if.valid;
  assign out_last       = u_out_if.last;
  assign led            = r_led;

endmodule

// File: tb/tb_sum_decode.sv
// Self-checking bench for sum_decode: directed frame scenarios plus a random
// run, all compared every cycle against a behavioural reference model.
module tb_sum_decode;
  import sum_pkg::*;

  localparam int N = 8;
  localparam int W = 8;

  logic         clk_25mhz = 1'b0;
  logic         reset     = 1'b1;
  logic         clr       = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_data   = '0;
  logic         in_ready;
  logic [7:0]   led;

  sum_decode_if #(.W(W)) out_if ();
  assign out_if.ready = out_ready;

  always #20 clk_25mhz = ~clk_25mhz;

  sum_decode #(.N(N), .W(W)) dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_if.data),
    .out_valid (out_if.valid),
    .out_ready (out_ready),
    .out_last  (out_if.last),
    .led       (led)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position, previous sample and the pending output word.
  int m_pos   = 0;
  int m_prev  = 0;
  int m_data  = 0;
  int m_led   = 0;
  bit m_valid = 1'b0;
  bit m_last  = 1'b0;

  always @(posedge clk_25mhz) begin : model
    bit acc;
    if (reset) begin
      m_pos = 0; m_prev = 0; m_data = 0; m_led = 0; m_valid = 1'b0; m_last = 1'b0;
    end else begin
      acc = in_valid && !clr && (!m_valid || out_ready);
      if (clr) begin
        m_pos  = 0;
        m_prev = 0;
      end
      if (acc) begin
        m_data  = (m_pos == 0) ? int'(in_data) : (int'(in_data) - m_prev + 256) % 256;
        m_last  = (m_pos == N - 1);
        m_valid = 1'b1;
        if (m_pos == N - 1) m_led = int'(in_data);
        m_prev = int'(in_data);
        m_pos  = (m_pos + 1) % N;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk_25mhz) begin
    if (chk_en) begin
      check("in_ready",  in_ready,     !reset && !clr && (!m_valid || out_ready));
      check("out_valid", out_if.valid, m_valid);
      check("out_data",  out_if.data,  m_data);
      check("out_last",  out_if.last,  m_last);
      check("led",       led,          m_led);
    end
  end

  // Every output transfer, as {last, data}, in order.
  logic [8:0] outq[$];
  always @(negedge clk_25mhz) begin
    if (out_if.valid && out_ready && !reset) outq.push_back({out_if.last, out_if.data});
  end

  int exp_a[16];
  int exp_n;

  task automatic check_q(input string tag);
    check({tag, "_count"}, outq.size(), exp_n);
    for (int i = 0; i < exp_n && i < outq.size(); i++) begin
      check({tag, "_data"}, outq[i][7:0], exp_a[i]);
      check({tag, "_last"}, outq[i][8], (i % N) == N - 1);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_25mhz);
      #1;
    end
  endtask

  task automatic send(input int d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d[W-1:0];
    @(negedge clk_25mhz);
    while (!in_ready && n < 50) begin
      @(negedge clk_25mhz);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: sample %0d not accepted within 50 cycles", d);
    end
    @(posedge clk_25mhz);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int frame[8] = '{0, 1, 3, 6, 10, 15, 21, 28};
    int rnd[16];

    // Reset state
    @(posedge clk_25mhz);
    #1;
    chk_en = 1'b1;
    check("rst_out_valid", out_if.valid, 0);
    check("rst_led", led, 0);
    check("rst_in_ready", in_ready, 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Full frame
    outq.delete();
    for (int i = 0; i < 8; i++) begin
      send(frame[i]);
      if (i == 6) check("frame_led_hold", led, 0);
    end
    check("frame_led", led, 28);
    cyc(2);
    for (int i = 0; i < 8; i++) exp_a[i] = i;
    exp_n = 8;
    check_q("frame");

    // Wrap-around modulo 2^W
    outq.delete();
    send(250);
    send(4);
    cyc(2);
    exp_a[0] = 250; exp_a[1] = 10; exp_n = 2;
    check_q("wrap");
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;

    // Backpressure mid-frame
    outq.delete();
    send(0); send(1); send(3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd6;
    repeat (3) begin
      @(negedge clk_25mhz);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", out_if.data, 2);
    end
    @(posedge clk_25mhz);
    #1;
    out_ready = 1'b1;
    for (int i = 3; i < 8; i++) send(frame[i]);
    cyc(2);
    for (int i = 0; i < 8; i++) exp_a[i] = i;
    exp_n = 8;
    check_q("bp");

    // Back-to-back frames at full rate
    outq.delete();
    for (int i = 0; i < 16; i++) rnd[i] = $urandom_range(0, 255);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = rnd[i][7:0];
      @(negedge clk_25mhz);
      check("b2b_ready", in_ready, 1);
      @(posedge clk_25mhz);
      #1;
    end
    in_valid = 1'b0;
    cyc(2);
    for (int i = 0; i < 16; i++)
      exp_a[i] = (i % N == 0) ? rnd[i] : (rnd[i] - rnd[i-1] + 256) % 256;
    exp_n = 16;
    check_q("b2b");
    if (outq.size() > 8) check("b2b_pass9", outq[8][7:0], rnd[8]);
    check("b2b_led", led, rnd[15]);

    // Reset mid-frame discards the partial frame
    send(11); send(22); send(33); send(44);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("midrst_led", led, 0);
    check("midrst_valid", out_if.valid, 0);
    outq.delete();
    send(5);
    send(7);
    check("midrst_led_hold", led, 0);
    cyc(2);
    exp_a[0] = 5; exp_a[1] = 2; exp_n = 2;
    check_q("midrst");
    for (int i = 8; i < 14; i++) send(i);
    check("midrst_led_done", led, 13);

    // clr beats a simultaneous valid sample
    send(10);
    send(20);
    cyc(2);
    outq.delete();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(negedge clk_25mhz);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk_25mhz);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    cyc(2);
    check("clr_no_accept", outq.size(), 0);
    send(42);
    cyc(2);
    exp_a[0] = 42; exp_n = 1;
    check_q("clr");

    // Random traffic against the model
    repeat (3000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 49) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    in_valid  = 1'b0;
    clr       = 1'b0;
    reset     = 1'b0;
    out_ready = 1'b1;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_decode.md
SUM_DECODE -- requirements
Module: sum_decode

Interface
REQ-001 SHALL have parameter N, default 8, giving samples per frame (N >= 2).
REQ-002 SHALL have parameter W, default 8, giving the data width in bits.
REQ-003 SHALL have port clk_25mhz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port clr, input, 1 bit: synchronous frame restart.
REQ-006 SHALL have port in_data, input, W bits: running (prefix) sum sample.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts in_data.
REQ-009 SHALL have port out_data, output, W bits: recovered element.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: sink accepts out_data.
REQ-012 SHALL have port out_last, output, 1 bit: out_data is element N-1 of its frame.
REQ-013 SHALL have port led, output, 8 bits: final prefix sum of the last completed frame, low 8 bits, zero-extended if W < 8.

Function
REQ-014 SHALL define input transfer as in_valid && in_ready, and output transfer as out_valid && out_ready, both sampled at a clock edge.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (combinational; single output register, no bubble under continuous flow).
REQ-016 SHALL, on input transfer at frame index 0, load out_data = in_data.
REQ-017 SHALL, on input transfer at index k > 0, load out_data = (in_data - prev) mod 2^W, where prev is the previous accepted sample of the same frame.
REQ-018 SHALL, on every input transfer, store prev = in_data.
REQ-019 SHALL set out_last on the output produced from index N-1, and clear it otherwise.
REQ-020 SHALL give latency of exactly 1 cycle from input transfer to out_valid high.
REQ-021 SHALL hold out_data, out_valid and out_last stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after an output transfer in a cycle with no input transfer.
REQ-023 SHALL implement a 2-state FSM: FIRST (index 0 expected) -> RUN on transfer; RUN -> FIRST on the transfer at index N-1; RUN stays RUN otherwise.
REQ-024 SHALL count the index 0..N-1 with a ceil(log2 N)-bit counter, wrapping to 0 after N-1.
REQ-025 SHALL update led with in_data on the transfer at index N-1; led SHALL otherwise hold.
REQ-026 SHALL, when clr is high, return the FSM to FIRST, set the index to 0 and prev to 0, and force in_ready low for that cycle; clr SHALL NOT alter out_valid/out_data/out_last or led.
REQ-027 SHALL give clr priority over a simultaneous in_valid; the sample is not accepted.
REQ-028 SHALL keep the wrap behaviour modulo 2^W with no overflow flag.

Reset
REQ-029 SHALL, when reset is high at a clock edge, clear out_valid, out_data, out_last, led, prev and the index to 0, and set the FSM to FIRST.
REQ-030 SHALL give reset priority over clr and over all transfers; in_ready SHALL be 0 in a reset cycle.
REQ-031 SHALL discard a partial frame on mid-frame reset; the next accepted sample is index 0.

Structure
REQ-032 SHALL place the FSM state encoding (FIRST, RUN) and defaults N=8 and W=8 in a shared package, sum_pkg.
REQ-033 SHALL be single-level with no sub-module; the output register stage MAY be factored as sub-module sum_out_reg.

Verification
REQ-034 SHALL test a full frame: inputs 0,1,3,6,10,15,21,28 with out_ready=1 -> outputs 0..7; out_last only on 7; led=28 one cycle after the last input.
REQ-035 SHALL test wrap-around with W=8: inputs 250,4 -> outputs 250,10.
REQ-036 SHALL test backpressure: out_ready=0 for 3 cycles mid-frame -> in_ready=0; out_data held; no loss or duplication; the full-frame sequence is still 0..7.
REQ-037 SHALL test back-to-back frames (16 samples, continuous valid/ready) -> throughput 1/cycle; the 9th input passes through unchanged; out_last on the 8th and 16th outputs.
REQ-038 SHALL test reset after 4 samples: the next inputs 5,7 -> outputs 5,2; led=0 until the frame completes.
REQ-039 SHALL test clr and in_valid together: the sample is not accepted and in_ready=0; the next accepted sample passes through unchanged.
